// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divider helpers.
// Used by uart_fifo_tx and the planned uart_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // A divider of 1 still needs a 1-bit counter so the port widths stay legal.
  function automatic int calc_cnt_w(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter with a synchronous clear; bit_end flags the last clock of a bit.
// The counter wraps to zero on bit_end, so every bit is exactly DIV clocks.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = calc_cnt_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART 8N1 transmitter draining a FIFO with an empty/pop/asynchronous-read interface.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  if (DIV < 2) begin : g_div_check
    $error("uart_fifo_tx: CLK_FREQ/BAUD must be at least 2");
  end

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 tx_r;
  logic                 bit_end;
  logic                 baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  // Holding the counter at zero in IDLE makes every frame start on a fresh bit period.
  assign baud_clr = (state == ST_IDLE);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !rst;
  assign tx_busy  = (state != ST_IDLE);
  assign tx_done  = (state == ST_STOP) && bit_end;
  assign tx       = tx_r;

  uart_baud_cnt #(
    .DIV(DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  // tx_r is loaded with the level of the state being entered, so the line changes on the entry edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_r    <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (!fifo_empty) begin
            shift  <= fifo_data;
`ifdef UART_TX_PARITY_EN
            parity <= ^fifo_data;
`endif
            state  <= ST_START;
            tx_r   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx_r    <= shift[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx_r  <= parity;
`else
              state <= ST_STOP;
              tx_r  <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              tx_r    <= shift[1];
              bit_idx <= bit_idx + BIT_IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx_r  <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            state <= ST_IDLE;
            tx_r  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx at DIV=10: FIFO model, per-cycle frame model and directed frame decoding.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CLKS_LIT = 110;
`else
  localparam int FRAME_BITS = 10;
  localparam int FRAME_CLKS_LIT = 100;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_fifo_tx #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  bit   [1:0] exp_q[$];
  logic [7:0] burst [3] = '{8'h00, 8'hFF, 8'h55};
  int n_checks = 0;
  int n_errors = 0;
  int pop_count = 0;
  bit check_en = 1'b0;
  bit pop_seen = 1'b0;
  bit noise = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic drive();
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) fifo_data = fifo_q[0];
    else if (noise)         fifo_data = 8'($urandom);
    else                    fifo_data = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_seen) begin
      if (fifo_q.size() != 0) fifo_q.delete(0);
      pop_seen = 1'b0;
    end
    drive();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive();
  endtask

  // Expected line activity for one byte: one {tx, done} entry per clock of the frame.
  task automatic build_frame(input logic [7:0] b);
    logic [FRAME_BITS-1:0] lv;
`ifdef UART_TX_PARITY_EN
    lv = {1'b1, ^b, b, 1'b0};
`else
    lv = {1'b1, b, 1'b0};
`endif
    for (int i = 0; i < FRAME_BITS; i++)
      for (int c = 0; c < DIV; c++)
        exp_q.push_back({lv[i], (i == FRAME_BITS - 1) && (c == DIV - 1)});
  endtask

  always @(negedge clk) begin : model_cmp
    logic [3:0] want;
    bit   [1:0] s;
    if (check_en) begin
      if (exp_q.size() == 0) begin
        want = {1'b1, 1'b0, 1'b0, (!rst && fifo_q.size() != 0)};
      end else begin
        s = exp_q.pop_front();
        want = {s[1], 1'b1, s[0], 1'b0};
      end
      check("cycle {tx,busy,done,pop}", 32'({tx, tx_busy, tx_done, fifo_pop}), 32'(want));
      if (fifo_pop === 1'b1) begin
        pop_count++;
        pop_seen = 1'b1;
      end
      if (rst) exp_q.delete();
      else if (want[0]) build_frame(fifo_q[0]);
    end
  end

  task automatic wait_fall(input int budget, output int n);
    logic prev;
    n = 0;
    prev = tx;
    while (n < budget) begin
      tick();
      n++;
      if (prev === 1'b1 && tx === 1'b0) return;
      prev = tx;
    end
    n_checks++;
    n_errors++;
    $display("FAIL start-bit wait: no tx falling edge within %0d clks", budget);
  endtask

  // Called in the first cycle of a frame; samples mid-bit and leaves the bench in the last STOP cycle.
  task automatic capture_frame(output logic [FRAME_BITS-1:0] bits, output int done_at);
    bits = '0;
    done_at = -1;
    for (int k = 1; k <= FRAME_CLKS; k++) begin
      if (k % DIV == DIV / 2) bits[(k - 1) / DIV] = tx;
      if (tx_done === 1'b1 && done_at < 0) done_at = k;
      if (k < FRAME_CLKS) tick();
    end
  endtask

  initial begin : main
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] a5_lit;
    int done_at;
    int n;
    int p0;

`ifdef UART_TX_PARITY_EN
    a5_lit = 11'b1_0_10100101_0;
`else
    a5_lit = 10'b1_10100101_0;
`endif

    drive();
    rst = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Empty FIFO: line idle, no pops.
    repeat (100) tick();
    check("idle pop count", 32'(pop_count), 32'd0);
    check("idle tx", 32'(tx), 32'd1);
    check("idle busy", 32'(tx_busy), 32'd0);

    // Single 0xA5 frame.
    p0 = pop_count;
    push(8'hA5);
    wait_fall(20, n);
    check("A5 pop-to-start latency", 32'(n), 32'd1);
    capture_frame(bits, done_at);
    check("A5 line bits", 32'(bits), 32'(a5_lit));
    check("A5 tx_done cycle", 32'(done_at), 32'(FRAME_CLKS_LIT));
    check("A5 pop count", 32'(pop_count - p0), 32'd1);
    check("A5 fifo empty", 32'(fifo_empty), 32'd1);
    repeat (5) tick();

    // Back-to-back burst.
    p0 = pop_count;
    for (int i = 0; i < 3; i++) fifo_q.push_back(burst[i]);
    drive();
    wait_fall(20, n);
    check("burst first latency", 32'(n), 32'd1);
    for (int i = 0; i < 3; i++) begin
      capture_frame(bits, done_at);
      check("burst byte", 32'(bits[8:1]), 32'(burst[i]));
      check("burst stop bit", 32'(bits[FRAME_BITS-1]), 32'd1);
      check("burst tx_done cycle", 32'(done_at), 32'(FRAME_CLKS_LIT));
      if (i < 2) begin
        wait_fall(20, n);
        check("burst stop-end to next start", 32'(n), 32'd2);
      end
    end
    tick();
    check("burst pop count", 32'(pop_count - p0), 32'd3);
    check("burst fifo empty", 32'(fifo_empty), 32'd1);
    repeat (5) tick();

    // Reset in clk 45 of a 0x3C frame with 0x81 queued.
    p0 = pop_count;
    push(8'h3C);
    push(8'h81);
    wait_fall(20, n);
    repeat (44) tick();
    rst = 1'b1;
    tick();
    check("abort tx high", 32'(tx), 32'd1);
    check("abort busy low", 32'(tx_busy), 32'd0);
    check("abort pop count", 32'(pop_count - p0), 32'd1);
    rst = 1'b0;
    wait_fall(20, n);
    check("post-reset latency", 32'(n), 32'd1);
    capture_frame(bits, done_at);
    check("post-reset byte", 32'(bits[8:1]), 32'h81);
    check("post-reset start bit", 32'(bits[0]), 32'd0);
    repeat (30) tick();
    check("post-reset pop count", 32'(pop_count - p0), 32'd2);
    check("post-reset fifo empty", 32'(fifo_empty), 32'd1);

    // Random fifo_data while empty and during a frame.
    noise = 1'b1;
    p0 = pop_count;
    repeat (60) tick();
    check("noise pop count", 32'(pop_count - p0), 32'd0);
    check("noise tx", 32'(tx), 32'd1);
    push(8'h5A);
    wait_fall(20, n);
    capture_frame(bits, done_at);
    check("noise frame byte", 32'(bits[8:1]), 32'h5A);
    noise = 1'b0;
    repeat (5) tick();
    check("noise frame pop count", 32'(pop_count - p0), 32'd1);

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    push(8'h03);
    wait_fall(20, n);
    capture_frame(bits, done_at);
    check("parity 0x07 byte", 32'(bits[8:1]), 32'h07);
    check("parity 0x07 bit", 32'(bits[9]), 32'd1);
    check("parity 0x07 frame length", 32'(done_at), 32'd110);
    wait_fall(20, n);
    check("parity gap", 32'(n), 32'd2);
    capture_frame(bits, done_at);
    check("parity 0x03 byte", 32'(bits[8:1]), 32'h03);
    check("parity 0x03 bit", 32'(bits[9]), 32'd0);
    repeat (5) tick();
`endif

    check("final tx idle", 32'(tx), 32'd1);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
